// File: rtl/record_timer_pkg.sv
// Shared types and constants for the recorder elapsed-seconds timer.
package record_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } timerState_e;

    // Code the seven-segment decoder renders as a blank display.
    localparam logic [5:0] TIME_BLANK = 6'd63;

    function automatic int blinkHalfCycles(input int cyclesPerSec);
        return (cyclesPerSec / 2 < 1) ? 1 : cyclesPerSec / 2;
    endfunction

endpackage

// File: rtl/record_timer_if.sv
// Strobe/status bundle between the record/play control FSM and the timer.
interface record_timer_if;

    logic       i_start;
    logic       i_pause;
    logic       i_stop;
    logic [5:0] o_time;
    logic       o_running;
    logic       o_done;

    modport master (
        output i_start, i_pause, i_stop,
        input  o_time, o_running, o_done
    );

    modport slave (
        input  i_start, i_pause, i_stop,
        output o_time, o_running, o_done
    );

endinterface

// File: rtl/record_timer_sec_tick_gen.sv
// Prescaler that emits a one-cycle tick every CYCLES_PER_SEC enabled cycles.
module sec_tick_gen #(
    parameter int CYCLES_PER_SEC = 50_000_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int             CNT_W = $clog2(CYCLES_PER_SEC);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES_PER_SEC - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign o_tick = i_en && (count_q == LAST);

    // Clear outranks enable so a restart always begins a full second.
    always_comb begin
        count_d = count_q;
        if (i_clr) begin
            count_d = '0;
        end else if (i_en) begin
            count_d = (count_q == LAST) ? '0 : count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/record_timer.sv
// Elapsed-seconds timer with start/pause/stop strobes and a done pulse.
// Optional RECORD_TIMER_BLINK_EN makes the display blink while paused.
module record_timer
    import record_timer_pkg::*;
#(
    parameter int CYCLES_PER_SEC = 50_000_000,
    parameter int MAX_SEC        = 32
) (
    input  logic          i_clk,
    input  logic          i_rst,
    record_timer_if.slave bus
);

    localparam logic [5:0] MAX_CODE = 6'(MAX_SEC);

    timerState_e state_q;
    timerState_e state_d;
    logic [5:0]  time_q;
    logic [5:0]  time_d;
    logic [5:0]  timeInc;
    logic        running_q;
    logic        done_q;
    logic        done_d;
    logic        tickEn;
    logic        tickClr;
    logic        tick;

    sec_tick_gen #(
        .CYCLES_PER_SEC(CYCLES_PER_SEC)
    ) u_tick (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (tickEn),
        .i_clr  (tickClr),
        .o_tick (tick)
    );

    // Every cycle spent in RUN advances the prescaler, including the cycle a
    // pause strobe arrives, so no partial second is lost across a pause.
    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        done_d  = 1'b0;
        tickEn  = (state_q == RUN);
        tickClr = 1'b0;
        timeInc = time_q + 6'd1;

        if (bus.i_stop) begin
            state_d = IDLE;
            time_d  = TIME_BLANK;
            tickClr = 1'b1;
        end else if (bus.i_start) begin
            state_d = RUN;
            time_d  = 6'd0;
            tickClr = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (tick) begin
                        time_d = timeInc;
                        if (timeInc == MAX_CODE) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else if (bus.i_pause) begin
                            state_d = PAUSE;
                        end
                    end else if (bus.i_pause) begin
                        state_d = PAUSE;
                    end
                end
                PAUSE: begin
                    if (bus.i_pause) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            time_q    <= TIME_BLANK;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            time_q    <= time_d;
            running_q <= (state_d == RUN);
            done_q    <= done_d;
        end
    end

    assign bus.o_running = running_q;
    assign bus.o_done    = done_q;

`ifdef RECORD_TIMER_BLINK_EN
    localparam int BLINK_HALF = blinkHalfCycles(CYCLES_PER_SEC);
    localparam int BLINK_W    = $clog2(2 * BLINK_HALF);

    logic [BLINK_W-1:0] blinkCnt_q;
    logic [BLINK_W-1:0] blinkCnt_d;
    logic [5:0]         display_q;
    logic [5:0]         display_d;

    // Blink counter restarts on PAUSE entry; first half-period shows the value.
    always_comb begin
        blinkCnt_d = '0;
        if (state_d == PAUSE && state_q == PAUSE) begin
            blinkCnt_d = (blinkCnt_q == BLINK_W'(2 * BLINK_HALF - 1)) ?
                         '0 : blinkCnt_q + BLINK_W'(1);
        end
        display_d = time_d;
        if (state_d == PAUSE && blinkCnt_d >= BLINK_W'(BLINK_HALF)) begin
            display_d = TIME_BLANK;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            blinkCnt_q <= '0;
            display_q  <= TIME_BLANK;
        end else begin
            blinkCnt_q <= blinkCnt_d;
            display_q  <= display_d;
        end
    end

    assign bus.o_time = display_q;
`else
    assign bus.o_time = time_q;
`endif

endmodule

// File: tb/tb_record_timer.sv
// Directed plus random bench for record_timer against a running-cycle model.
module tb_record_timer;

    localparam int CPS  = 4;
    localparam int MAX  = 3;
    localparam int HALF = (CPS / 2 < 1) ? 1 : CPS / 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    record_timer_if bus ();

    record_timer #(
        .CYCLES_PER_SEC(CPS),
        .MAX_SEC       (MAX)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int step     = 0;

    // Model: elapsed seconds are simply running cycles divided by CPS.
    bit mIdle     = 1'b1;
    bit mPaused   = 1'b0;
    bit mFinished = 1'b0;
    int runCycles = 0;
    int pauseCycles = 0;
    bit expDone   = 1'b0;

    function automatic void stepModel(input bit r, input bit s, input bit p, input bit t);
        expDone = 1'b0;
        if (r || t) begin
            mIdle = 1'b1; mPaused = 1'b0; mFinished = 1'b0; runCycles = 0;
        end else if (s) begin
            mIdle = 1'b0; mPaused = 1'b0; mFinished = 1'b0; runCycles = 0;
        end else if (mIdle || mFinished) begin
            runCycles = runCycles;
        end else if (mPaused) begin
            if (p) mPaused = 1'b0;
            else pauseCycles = pauseCycles + 1;
        end else begin
            runCycles = runCycles + 1;
            if (runCycles / CPS == MAX) begin
                mFinished = 1'b1;
                expDone   = 1'b1;
            end else if (p) begin
                mPaused     = 1'b1;
                pauseCycles = 0;
            end
        end
    endfunction

    task automatic checkOutput();
        logic [5:0] eTime;
        logic       eRun;
        eTime = mIdle ? 6'd63 : 6'(runCycles / CPS);
`ifdef RECORD_TIMER_BLINK_EN
        if (!mIdle && mPaused && ((pauseCycles / HALF) % 2 == 1)) eTime = 6'd63;
`endif
        eRun = !mIdle && !mPaused && !mFinished;
        checks++;
        assert (bus.o_time === eTime) else begin
            failures++;
            $error("[TB] FAIL time step=%0d observed=%0d expected=%0d", step, bus.o_time, eTime);
        end
        checks++;
        assert (bus.o_running === eRun) else begin
            failures++;
            $error("[TB] FAIL running step=%0d observed=%0b expected=%0b", step, bus.o_running, eRun);
        end
        checks++;
        assert (bus.o_done === expDone) else begin
            failures++;
            $error("[TB] FAIL done step=%0d observed=%0b expected=%0b", step, bus.o_done, expDone);
        end
        step++;
    endtask

    task automatic applyStimulus(input bit r, input bit s, input bit p, input bit t);
        rst         = r;
        bus.i_start = s;
        bus.i_pause = p;
        bus.i_stop  = t;
        @(posedge clk);
        stepModel(r, s, p, t);
        #1;
        checkOutput();
    endtask

    initial begin
        $display("[TB] reset and idle");
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 0);

        $display("[TB] full run to MAX_SEC");
        applyStimulus(0, 1, 0, 0);
        for (int i = 0; i < 16; i++) applyStimulus(0, 0, 0, 0);

        $display("[TB] pause and resume");
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0);
        for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0);
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0);

        $display("[TB] stop coincident with final tick");
        applyStimulus(0, 1, 0, 0);
        for (int i = 0; i < 11; i++) applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0);

        $display("[TB] start with stop");
        applyStimulus(0, 1, 0, 1);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);

        $display("[TB] reset mid-run, then lone pause");
        applyStimulus(0, 1, 0, 0);
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 1, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0);

        $display("[TB] pause at one second");
        applyStimulus(0, 1, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0);
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0);

        $display("[TB] random strobes");
        for (int i = 0; i < 600; i++) begin
            bit r, s, p, t;
            r = ($urandom_range(0, 99) < 1);
            s = ($urandom_range(0, 99) < 4);
            p = ($urandom_range(0, 99) < 12);
            t = ($urandom_range(0, 99) < 3);
            applyStimulus(r, s, p, t);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/record_timer.md
Name: record_timer

Overview:
- Elapsed-seconds timer for the recorder datapath.
- Produces the 6-bit time code consumed by the seven-segment time display: values 0..62 are seconds, and 63 is the blank code shown when idle.
- Driven by the record/play control FSM through start/pause/stop strobes.
- Signals completion when the configured maximum length is reached.

Parameters:
- CYCLES_PER_SEC, 50_000_000, clock cycles per second. Must be >= 2.
- MAX_SEC, 32, maximum timed length in seconds. Legal range 1..62.

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  1-cycle strobe: clear time to 0 and begin counting.
- i_pause  in  1  1-cycle strobe: toggle between counting and paused.
- i_stop  in  1  1-cycle strobe: abort and return to idle/blank.
- o_time  out  6  seconds elapsed (0..MAX_SEC); 63 = blank/idle.
- o_running  out  1  high while in RUN.
- o_done  out  1  1-cycle pulse when MAX_SEC is reached.

Behaviour:
- Reset (i_rst=1 at a clock edge), including mid-operation:
  - state=IDLE, o_time=63, o_running=0, o_done=0, prescaler=0.
- States: IDLE, RUN, PAUSE, DONE. All outputs are registered.
- Strobe priority in the same cycle: i_stop > i_start > i_pause.
- IDLE:
  - i_start -> RUN; next cycle o_time=0, prescaler=0.
  - i_pause is ignored.
- RUN:
  - Prescaler counts 0..CYCLES_PER_SEC-1. At CYCLES_PER_SEC-1 it wraps to 0 and seconds increment.
  - First increment occurs exactly CYCLES_PER_SEC cycles after o_time becomes 0.
  - If the incremented value equals MAX_SEC: go to DONE, o_time=MAX_SEC, and o_done=1 in that same cycle only.
- PAUSE:
  - Prescaler and o_time hold their values.
  - i_pause -> RUN, resuming from the held prescaler value (no loss of partial seconds).
- DONE:
  - o_time holds MAX_SEC; o_running=0.
  - i_pause is ignored.
  - i_start restarts counting from 0.
- i_stop in any state -> IDLE; o_time=63 next cycle; no o_done pulse.
  - This holds even if a second tick coincides with the stop.
- i_start in RUN/PAUSE: restart, with o_time=0 and prescaler=0 next cycle.
- Tick and i_pause in the same RUN cycle: the tick is applied (o_time increments), then the state goes to PAUSE with prescaler=0.
- Tick reaching MAX_SEC together with i_pause: DONE wins and o_done pulses.
- Prescaler width is $clog2(CYCLES_PER_SEC). Seconds are 6-bit and never exceed MAX_SEC, so the value 63 is never reachable by counting.

Optional Feature:
- Macro: RECORD_TIMER_BLINK_EN.
- Defined: in PAUSE, o_time alternates between the held value and 63 (blank).
  - Each phase lasts CYCLES_PER_SEC/2 cycles (integer division, minimum 1).
  - Uses a separate blink counter that is cleared on entry to PAUSE; the displayed value is shown first.
  - On leaving PAUSE, o_time immediately shows the true value.
- Undefined: o_time holds steady in PAUSE; no blink counter is synthesized.

Decomposition:
- Package record_timer_pkg contains:
  - state enum (IDLE, RUN, PAUSE, DONE);
  - localparam TIME_BLANK = 6'd63, shared with the display decoder.
- One sub-module, sec_tick_gen:
  - Prescaler with enable and clear.
  - Emits a 1-cycle tick on wrap.
  - Parameterised by CYCLES_PER_SEC.

Test Plan (CYCLES_PER_SEC=4, MAX_SEC=3 unless noted):
- Reset then idle for 20 cycles -> o_time=63, o_running=0, o_done never high.
- i_start at cycle 0 -> o_time=0 at cycle 1, 1 at cycle 5, 2 at cycle 9, 3 at cycle 13. o_done high only at cycle 13. Then o_time holds 3 and o_running=0.
- Start; i_pause at prescaler=2; wait 10 cycles; i_pause again -> o_time is frozen during the pause, and the next increment arrives 2 cycles after resume.
- i_stop coincident with the tick to MAX_SEC -> o_time=63 next cycle, o_done stays 0, state IDLE. Also: i_start and i_stop in the same cycle -> IDLE.
- i_rst asserted mid-RUN at o_time=2 -> next cycle o_time=63. i_pause alone afterwards has no effect.
- With RECORD_TIMER_BLINK_EN defined, pause at o_time=1 -> o_time shows 1,1,63,63 repeating every 4 cycles. Resume -> steady 1.
